// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED frame writer slice: panel geometry, the
// channel write mask presented to the panel driver, the writer state
// encoding and the 8-bit to INPUT_DEPTH-bit channel packing helper.
//
// Optional feature macro used by files that import this package:
//    LED_FRAME_WRITER_BRIGHTNESS_EN
// ---------------------------------------------------------------------------
package led_pkg;

   // Geometry of a single panel; the line width scales with the chain length
   localparam int PANEL_W_BASE = 64;
   localparam int PANEL_ROWS   = 64;

   // Only R, G and B memories are ever written; the fourth lane stays masked
   localparam logic [3:0] WR_MASK_RGB = 4'b0111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      CLEAR  = 2'd2
   } state_e;

   // Keep the top 'depth' bits of every 8-bit channel and right-align them in
   // their byte lane; bits above 'depth' are forced to zero. Plain truncation,
   // no rounding, so a full-scale channel maps to the full-scale code.
   function automatic logic [23:0] packChannels(input logic [23:0] color,
                                                input int          depth);
      logic [23:0] result;
      result = '0;
      for (int k = 0; k < 3; k++) begin
         for (int b = 0; b < 8; b++) begin
            if (b < depth) begin
               result[k*8 + b] = color[k*8 + (8 - depth) + b];
            end
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/led_color_pack.sv
// ---------------------------------------------------------------------------
// led_color_pack
// Converts a 24-bit {R,G,B} colour into the packed video-memory word: each
// channel truncated to INPUT_DEPTH bits in the low end of its byte. Purely
// combinational; the caller supplies the pipeline registers. One instance is
// shared by the pixel stream and the clear-fill path.
//
// Ports:
//    i_color       24-bit {R[7:0],G[7:0],B[7:0]} input colour
//    i_brightness  8-bit brightness scale (only with LED_FRAME_WRITER_BRIGHTNESS_EN)
//    o_packed      24-bit packed video-memory word
//
// Macro: LED_FRAME_WRITER_BRIGHTNESS_EN adds the brightness scaling stage
// (ch*brightness)>>8 ahead of the truncation.
// ---------------------------------------------------------------------------
module led_color_pack
   #(parameter int INPUT_DEPTH = 6)
   (
      input  logic [23:0] i_color,
`ifdef LED_FRAME_WRITER_BRIGHTNESS_EN
      input  logic [7:0]  i_brightness,
`endif
      output logic [23:0] o_packed
   );

   import led_pkg::*;

   logic [23:0] w_scaled;

`ifdef LED_FRAME_WRITER_BRIGHTNESS_EN
   // Scale each channel by brightness/256; a brightness of 255 therefore
   // knocks one code off any non-zero channel, which is the intended formula
   always_comb begin
      w_scaled = '0;
      for (int k = 0; k < 3; k++) begin
         w_scaled[k*8 +: 8] = 8'((16'(i_color[k*8 +: 8]) * 16'(i_brightness)) >> 8);
      end
   end
`else
   assign w_scaled = i_color;
`endif

   assign o_packed = packChannels(w_scaled, INPUT_DEPTH);

endmodule

// File: rtl/led_frame_writer.sv
// ---------------------------------------------------------------------------
// led_frame_writer
// Upstream stage of the LED panel driver (ctrl_clk domain). Turns a raster
// pixel stream into one video-memory write per accepted beat, offers a
// hardware clear that fills the whole memory with one colour, and flags
// frame completion and stream synchronisation problems.
//
// Ports:
//    ctrl_clk     clock
//    reset        synchronous, active-high reset
//    s_valid      pixel beat valid
//    s_ready      beat accepted when s_valid & s_ready (combinational)
//    s_sof        beat is pixel (row 0, col 0)
//    s_data       pixel {R[7:0],G[7:0],B[7:0]}
//    clear_req    one-cycle request to fill memory with clear_color
//    clear_color  fill colour, captured when clear_req is accepted
//    brightness   8-bit scale (only with LED_FRAME_WRITER_BRIGHTNESS_EN)
//    ctrl_en      write strobe to the panel driver
//    ctrl_wr      channel write mask, 4'b0111 while ctrl_en is high
//    ctrl_addr    {row[5:0], col} zero-extended to 16 bits
//    ctrl_wdat    packed colour, INPUT_DEPTH bits per byte lane
//    busy         writer is not idle
//    frame_done   one-cycle pulse the cycle after the last pixel's write
//    sync_err     one-cycle pulse on a resync or a discarded beat
//
// Macro: LED_FRAME_WRITER_BRIGHTNESS_EN adds the brightness port and one
// extra pipeline stage on the write path (write lands at N+2 instead of N+1).
// ---------------------------------------------------------------------------
module led_frame_writer
   #(
      parameter int CHAINED     = 2,
      parameter int INPUT_DEPTH = 6
   )
   (
      input  logic        ctrl_clk,
      input  logic        reset,
      input  logic        s_valid,
      output logic        s_ready,
      input  logic        s_sof,
      input  logic [23:0] s_data,
      input  logic        clear_req,
      input  logic [23:0] clear_color,
`ifdef LED_FRAME_WRITER_BRIGHTNESS_EN
      input  logic [7:0]  brightness,
`endif
      output logic        ctrl_en,
      output logic [3:0]  ctrl_wr,
      output logic [15:0] ctrl_addr,
      output logic [23:0] ctrl_wdat,
      output logic        busy,
      output logic        frame_done,
      output logic        sync_err
   );

   import led_pkg::*;

   localparam int SB     = $clog2(CHAINED);
   localparam int CW     = 6 + SB;
   localparam int LINE_W = PANEL_W_BASE * CHAINED;

   localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
   localparam logic [5:0]    ROW_LAST = 6'(PANEL_ROWS - 1);

   localparam logic [1:0] ST_IDLE   = 2'(IDLE);
   localparam logic [1:0] ST_STREAM = 2'(STREAM);
   localparam logic [1:0] ST_CLEAR  = 2'(CLEAR);

   logic [1:0]    r_state;
   logic [CW-1:0] r_col;
   logic [5:0]    r_row;
   logic [23:0]   r_clearColor;

   logic [1:0]    w_nextState;
   logic [CW-1:0] w_nextCol;
   logic [5:0]    w_nextRow;
   logic [CW-1:0] w_wrCol;
   logic [5:0]    w_wrRow;
   logic [15:0]   w_wrAddr;
   logic          w_wrEn;
   logic          w_wrFromClear;
   logic          w_wrLast;
   logic          w_wrErr;
   logic [23:0]   w_srcColor;

   logic          w_accept;
   logic          w_clearAccept;
   logic          w_atLineEnd;
   logic          w_atFrameEnd;
   logic          w_atOrigin;

   logic          w_outEn;
   logic [15:0]   w_outAddr;
   logic          w_outLast;
   logic          w_outErr;
   logic [23:0]   w_packed;

   logic          r_ctrlEn;
   logic [15:0]   r_ctrlAddr;
   logic [23:0]   r_ctrlWdat;
   logic          r_wrLast;
   logic          r_syncErr;
   logic          r_frameDone;

   // A pending clear request steals the cycle from the stream, and nothing
   // is taken from upstream while the fill is running
   assign s_ready       = (r_state != ST_CLEAR) && !clear_req;
   assign w_accept      = s_valid && s_ready;
   assign w_clearAccept = clear_req && (r_state != ST_CLEAR);

   assign w_atLineEnd  = (r_col == COL_LAST);
   assign w_atFrameEnd = w_atLineEnd && (r_row == ROW_LAST);
   assign w_atOrigin   = (r_col == '0) && (r_row == '0);

   // Next-state and write-request decode. Stream and clear both walk the
   // same row-major raster counter, so the advance logic is shared; the only
   // differences are where the colour comes from and whether the final pixel
   // raises frame_done.
   always_comb begin
      w_nextState   = r_state;
      w_nextCol     = r_col;
      w_nextRow     = r_row;
      w_wrEn        = 1'b0;
      w_wrCol       = r_col;
      w_wrRow       = r_row;
      w_wrFromClear = 1'b0;
      w_wrLast      = 1'b0;
      w_wrErr       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_clearAccept) begin
               w_nextState = ST_CLEAR;
               w_nextCol   = '0;
               w_nextRow   = '0;
            end else if (w_accept) begin
               if (s_sof) begin
                  w_wrEn      = 1'b1;
                  w_wrCol     = '0;
                  w_wrRow     = '0;
                  w_nextCol   = CW'(1);
                  w_nextRow   = '0;
                  w_nextState = ST_STREAM;
               end else begin
                  w_wrErr = 1'b1;
               end
            end
         end

         ST_STREAM: begin
            if (w_clearAccept) begin
               w_nextState = ST_CLEAR;
               w_nextCol   = '0;
               w_nextRow   = '0;
            end else if (w_accept) begin
               w_wrEn = 1'b1;
               if (s_sof && !w_atOrigin) begin
                  w_wrCol   = '0;
                  w_wrRow   = '0;
                  w_nextCol = CW'(1);
                  w_nextRow = '0;
                  w_wrErr   = 1'b1;
               end else if (w_atFrameEnd) begin
                  w_wrLast    = 1'b1;
                  w_nextCol   = '0;
                  w_nextRow   = '0;
                  w_nextState = ST_IDLE;
               end else if (w_atLineEnd) begin
                  w_nextCol = '0;
                  w_nextRow = r_row + 6'd1;
               end else begin
                  w_nextCol = r_col + CW'(1);
               end
            end
         end

         ST_CLEAR: begin
            w_wrEn        = 1'b1;
            w_wrFromClear = 1'b1;
            if (w_atFrameEnd) begin
               w_nextCol   = '0;
               w_nextRow   = '0;
               w_nextState = ST_IDLE;
            end else if (w_atLineEnd) begin
               w_nextCol = '0;
               w_nextRow = r_row + 6'd1;
            end else begin
               w_nextCol = r_col + CW'(1);
            end
         end

         default: begin
            w_nextState = ST_IDLE;
            w_nextCol   = '0;
            w_nextRow   = '0;
         end
      endcase
   end

   assign w_wrAddr   = 16'({w_wrRow, w_wrCol});
   assign w_srcColor = w_wrFromClear ? r_clearColor : s_data;

   // Raster state and the captured fill colour; the colour is latched on
   // acceptance so the requester may change clear_color during the fill
   always_ff @(posedge ctrl_clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_col        <= '0;
         r_row        <= '0;
         r_clearColor <= '0;
      end else begin
         r_state <= w_nextState;
         r_col   <= w_nextCol;
         r_row   <= w_nextRow;
         if (w_clearAccept) begin
            r_clearColor <= clear_color;
         end
      end
   end

`ifdef LED_FRAME_WRITER_BRIGHTNESS_EN
   logic          r_pEn;
   logic [15:0]   r_pAddr;
   logic [23:0]   r_pColor;
   logic          r_pLast;
   logic          r_pErr;

   // Extra stage so the multiply in the colour packer sits between two
   // registers; all write-side flags travel with the colour to stay aligned
   always_ff @(posedge ctrl_clk) begin
      if (reset) begin
         r_pEn    <= 1'b0;
         r_pAddr  <= '0;
         r_pColor <= '0;
         r_pLast  <= 1'b0;
         r_pErr   <= 1'b0;
      end else begin
         r_pEn    <= w_wrEn;
         r_pAddr  <= w_wrAddr;
         r_pColor <= w_srcColor;
         r_pLast  <= w_wrLast;
         r_pErr   <= w_wrErr;
      end
   end

   led_color_pack #(.INPUT_DEPTH(INPUT_DEPTH)) uColorPack (
      .i_color      (r_pColor),
      .i_brightness (brightness),
      .o_packed     (w_packed)
   );

   assign w_outEn   = r_pEn;
   assign w_outAddr = r_pAddr;
   assign w_outLast = r_pLast;
   assign w_outErr  = r_pErr;
`else
   led_color_pack #(.INPUT_DEPTH(INPUT_DEPTH)) uColorPack (
      .i_color  (w_srcColor),
      .o_packed (w_packed)
   );

   assign w_outEn   = w_wrEn;
   assign w_outAddr = w_wrAddr;
   assign w_outLast = w_wrLast;
   assign w_outErr  = w_wrErr;
`endif

   // Output register stage; address and data are zeroed on idle cycles so
   // the driver bus stays quiet. frame_done is delayed one more cycle from
   // the final write so it lands strictly after that write strobe.
   always_ff @(posedge ctrl_clk) begin
      if (reset) begin
         r_ctrlEn    <= 1'b0;
         r_ctrlAddr  <= '0;
         r_ctrlWdat  <= '0;
         r_wrLast    <= 1'b0;
         r_syncErr   <= 1'b0;
         r_frameDone <= 1'b0;
      end else begin
         r_ctrlEn    <= w_outEn;
         r_ctrlAddr  <= w_outEn ? w_outAddr : 16'h0000;
         r_ctrlWdat  <= w_outEn ? w_packed  : 24'h000000;
         r_wrLast    <= w_outEn && w_outLast;
         r_syncErr   <= w_outErr;
         r_frameDone <= r_wrLast;
      end
   end

   assign ctrl_en    = r_ctrlEn;
   assign ctrl_wr    = r_ctrlEn ? WR_MASK_RGB : 4'b0000;
   assign ctrl_addr  = r_ctrlAddr;
   assign ctrl_wdat  = r_ctrlWdat;
   assign busy       = (r_state != ST_IDLE);
   assign frame_done = r_frameDone;
   assign sync_err   = r_syncErr;

endmodule

// File: tb/tb_led_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_led_frame_writer
// Self-checking bench for led_frame_writer with CHAINED=2, INPUT_DEPTH=6
// (128-pixel lines, 8192-pixel frames). A table of single beats exercises
// the basic stream path and colour packing, followed by hand-written
// sequences for full frames, resync, row wrap, clear fill and reset.
// ---------------------------------------------------------------------------
module tb_led_frame_writer;

   logic        ctrl_clk = 1'b0;
   logic        reset;
   logic        s_valid;
   logic        s_ready;
   logic        s_sof;
   logic [23:0] s_data;
   logic        clear_req;
   logic [23:0] clear_color;
   logic        ctrl_en;
   logic [3:0]  ctrl_wr;
   logic [15:0] ctrl_addr;
   logic [23:0] ctrl_wdat;
   logic        busy;
   logic        frame_done;
   logic        sync_err;

   int vecCount  = 0;
   int missCount = 0;

   typedef struct {
      logic        valid;
      logic        sof;
      logic [23:0] data;
      logic        expEn;
      logic [15:0] expAddr;
      logic [23:0] expWdat;
      logic        expErr;
   } vec_t;

   vec_t vecTable [9];

   // Free-running control clock, 10 time units per period
   always #5 ctrl_clk = ~ctrl_clk;

   led_frame_writer #(.CHAINED(2), .INPUT_DEPTH(6)) dut (
      .ctrl_clk    (ctrl_clk),
      .reset       (reset),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_sof       (s_sof),
      .s_data      (s_data),
      .clear_req   (clear_req),
      .clear_color (clear_color),
      .ctrl_en     (ctrl_en),
      .ctrl_wr     (ctrl_wr),
      .ctrl_addr   (ctrl_addr),
      .ctrl_wdat   (ctrl_wdat),
      .busy        (busy),
      .frame_done  (frame_done),
      .sync_err    (sync_err)
   );

   task automatic applyStimulus(input logic valid, input logic sof, input logic [23:0] data);
      s_valid = valid;
      s_sof   = sof;
      s_data  = data;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Advance one clock and settle just past the edge before sampling
   task automatic tick();
      @(posedge ctrl_clk);
      #1;
   endtask

   // Main sequence: reset, beat table, then the multi-cycle scenarios
   initial begin
      int badFrame;
      int doneSeen;
      int clearWrites;
      int badClear;
      int found;

      vecTable[0] = '{1'b1, 1'b0, 24'hAABBCC, 1'b0, 16'h0000, 24'h000000, 1'b1};
      vecTable[1] = '{1'b1, 1'b1, 24'hFC8004, 1'b1, 16'h0000, 24'h3F2001, 1'b0};
      vecTable[2] = '{1'b1, 1'b0, 24'h123456, 1'b1, 16'h0001, 24'h040D15, 1'b0};
      vecTable[3] = '{1'b1, 1'b0, 24'hFFFFFF, 1'b1, 16'h0002, 24'h3F3F3F, 1'b0};
      vecTable[4] = '{1'b0, 1'b1, 24'hFFFFFF, 1'b0, 16'h0000, 24'h000000, 1'b0};
      vecTable[5] = '{1'b1, 1'b1, 24'h000000, 1'b1, 16'h0000, 24'h000000, 1'b1};
      vecTable[6] = '{1'b1, 1'b0, 24'h80FF01, 1'b1, 16'h0001, 24'h203F00, 1'b0};
      vecTable[7] = '{1'b1, 1'b0, 24'h7F0203, 1'b1, 16'h0002, 24'h1F0000, 1'b0};
      vecTable[8] = '{1'b1, 1'b0, 24'h04080C, 1'b1, 16'h0003, 24'h010203, 1'b0};

      reset       = 1'b1;
      clear_req   = 1'b0;
      clear_color = 24'h000000;
      applyStimulus(1'b0, 1'b0, 24'h000000);
      repeat (3) tick();
      reset = 1'b0;
      #1;
      checkOutput("reset_en",    ctrl_en,    0);
      checkOutput("reset_wr",    ctrl_wr,    0);
      checkOutput("reset_addr",  ctrl_addr,  0);
      checkOutput("reset_wdat",  ctrl_wdat,  0);
      checkOutput("reset_busy",  busy,       0);
      checkOutput("reset_done",  frame_done, 0);
      checkOutput("reset_err",   sync_err,   0);
      checkOutput("reset_ready", s_ready,    1);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecTable[i].valid, vecTable[i].sof, vecTable[i].data);
         tick();
         checkOutput($sformatf("vec%0d_en", i),  ctrl_en,  vecTable[i].expEn);
         checkOutput($sformatf("vec%0d_err", i), sync_err, vecTable[i].expErr);
         if (vecTable[i].expEn) begin
            checkOutput($sformatf("vec%0d_addr", i), ctrl_addr, vecTable[i].expAddr);
            checkOutput($sformatf("vec%0d_wdat", i), ctrl_wdat, vecTable[i].expWdat);
            checkOutput($sformatf("vec%0d_wr", i),   ctrl_wr,   4'b0111);
         end else begin
            checkOutput($sformatf("vec%0d_wr", i),   ctrl_wr,   4'b0000);
         end
      end
      applyStimulus(1'b0, 1'b0, 24'h000000);

      // Clear requested mid-frame together with a valid beat
      applyStimulus(1'b1, 1'b0, 24'h111111);
      clear_req   = 1'b1;
      clear_color = 24'hFFFFFF;
      #1;
      checkOutput("clr_sready_low", s_ready, 0);
      tick();
      clear_req   = 1'b0;
      clear_color = 24'h000000;
      applyStimulus(1'b1, 1'b0, 24'h222222);
      #1;
      checkOutput("clr_beat_dropped", ctrl_en, 0);
      checkOutput("clr_busy",         busy,    1);
      checkOutput("clr_sready_busy",  s_ready, 0);
      clearWrites = 0;
      badClear    = 0;
      doneSeen    = 0;
      for (int c = 0; c < 9000 && clearWrites < 8192; c++) begin
         tick();
         if (frame_done === 1'b1) doneSeen++;
         if (ctrl_en === 1'b1) begin
            if (ctrl_addr !== 16'(clearWrites) || ctrl_wdat !== 24'h3F3F3F || ctrl_wr !== 4'b0111)
               badClear++;
            clearWrites++;
         end
      end
      applyStimulus(1'b0, 1'b0, 24'h000000);
      checkOutput("clr_write_count", clearWrites, 8192);
      checkOutput("clr_bad_writes",  badClear,    0);
      checkOutput("clr_busy_after",  busy,        0);
      tick();
      checkOutput("clr_quiet_after", ctrl_en, 0);
      checkOutput("clr_no_done",     doneSeen + int'(frame_done), 0);

      // Full frame of constant colour
      badFrame = 0;
      doneSeen = 0;
      for (int i = 0; i < 8192; i++) begin
         applyStimulus(1'b1, (i == 0), 24'hFC8004);
         tick();
         if (ctrl_en !== 1'b1 || ctrl_addr !== 16'(i) || ctrl_wdat !== 24'h3F2001 ||
             ctrl_wr !== 4'b0111 || sync_err !== 1'b0)
            badFrame++;
         if (frame_done === 1'b1) doneSeen++;
      end
      applyStimulus(1'b0, 1'b0, 24'h000000);
      checkOutput("frame_bad_writes", badFrame,  0);
      checkOutput("frame_last_addr",  ctrl_addr, 16'h1FFF);
      checkOutput("frame_done_early", doneSeen,  0);
      tick();
      checkOutput("frame_done_pulse", frame_done, 1);
      checkOutput("frame_idle_en",    ctrl_en,    0);
      checkOutput("frame_idle_busy",  busy,       0);
      tick();
      checkOutput("frame_done_once",  frame_done, 0);

      // Resync at pixel 300, then row wrap from col 127 to row 1
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, (i == 0), 24'(i));
         tick();
      end
      checkOutput("rs_pre_addr", ctrl_addr, 16'd299);
      checkOutput("rs_pre_err",  sync_err,  0);
      applyStimulus(1'b1, 1'b1, 24'hFC8004);
      tick();
      checkOutput("rs_en",   ctrl_en,   1);
      checkOutput("rs_addr", ctrl_addr, 16'h0000);
      checkOutput("rs_err",  sync_err,  1);
      applyStimulus(1'b1, 1'b0, 24'h0C0C0C);
      tick();
      checkOutput("rs_next_addr", ctrl_addr, 16'h0001);
      checkOutput("rs_next_err",  sync_err,  0);
      for (int k = 2; k < 128; k++) begin
         applyStimulus(1'b1, 1'b0, 24'h0C0C0C);
         tick();
      end
      checkOutput("wrap_col127_addr", ctrl_addr, 16'h007F);
      checkOutput("wrap_col127_wdat", ctrl_wdat, 24'h030303);
      applyStimulus(1'b1, 1'b0, 24'h0C0C0C);
      tick();
      checkOutput("wrap_row1_addr", ctrl_addr, 16'h0080);
      applyStimulus(1'b0, 1'b0, 24'h000000);

      // Reset in the middle of a clear fill
      clear_req   = 1'b1;
      clear_color = 24'h808080;
      tick();
      clear_req = 1'b0;
      found     = 0;
      for (int c = 0; c < 500; c++) begin
         tick();
         if (ctrl_en === 1'b1 && ctrl_addr === 16'd100) begin
            found = 1;
            break;
         end
      end
      checkOutput("rst_reach_w100", found,     1);
      checkOutput("rst_w100_wdat",  ctrl_wdat, 24'h202020);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("rst_en",   ctrl_en, 0);
      checkOutput("rst_busy", busy,    0);
      applyStimulus(1'b1, 1'b1, 24'h04080C);
      tick();
      checkOutput("rst_sof_en",   ctrl_en,   1);
      checkOutput("rst_sof_addr", ctrl_addr, 16'h0000);
      checkOutput("rst_sof_wdat", ctrl_wdat, 24'h010203);
      applyStimulus(1'b1, 1'b0, 24'h04080C);
      tick();
      checkOutput("rst_next_addr", ctrl_addr, 16'h0001);
      applyStimulus(1'b0, 1'b0, 24'h000000);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/led_frame_writer.md
Name: led_frame_writer

Overview:
- Upstream stage of the LED panel driver, in the ctrl_clk domain.
- Accepts a raster pixel stream (valid/ready, start-of-frame marker, 8-bit RGB) and turns it into ctrl_en/ctrl_wr/ctrl_addr/ctrl_wdat video-memory writes for the panel driver.
- Provides a hardware frame-clear fill and reports frame completion and sync errors.

Parameters:
- CHAINED, 2, panels in chain; line width W = 64*CHAINED pixels, 64 rows.
- INPUT_DEPTH, 6, color bits per channel written to video memory (≤8).

Ports:
- ctrl_clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_valid  in  1  pixel beat valid
- s_ready  out  1  pixel beat accepted when s_valid&s_ready
- s_sof  in  1  beat is pixel (row 0, col 0)
- s_data  in  24  pixel {R[7:0],G[7:0],B[7:0]}
- clear_req  in  1  one-cycle request to fill whole memory with clear_color
- clear_color  in  24  fill color, sampled when clear_req is accepted
- ctrl_en  out  1  write strobe to panel driver
- ctrl_wr  out  4  channel write mask; always 4'b0111 when ctrl_en=1, else 0
- ctrl_addr  out  16  {row[5:0], col[5+SB:0]} zero-extended, SB=$clog2(CHAINED)
- ctrl_wdat  out  24  each channel in the low INPUT_DEPTH bits of its byte, upper bits 0
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written
- sync_err  out  1  one-cycle pulse on a resync or a dropped beat

Behaviour:
- Reset values:
  - State IDLE; col and row = 0.
  - All outputs 0, except s_ready = 1.
- Channel conversion: ch_out = ch_in[7:8-INPUT_DEPTH], truncation with no rounding, placed at ctrl_wdat[k*8 +: INPUT_DEPTH].
- s_ready is combinational: (state != CLEAR) && !clear_req.
- States:
  - IDLE: a beat with s_sof=1 writes address 0, sets col=1, and moves to STREAM. A beat with s_sof=0 is accepted and discarded, and pulses sync_err.
  - STREAM: each beat writes {row, col}, then col++.
    - col wraps at W-1 to 0 and row++.
    - A beat at row 63, col W-1 pulses frame_done one cycle after its write strobe and returns to IDLE.
    - A beat with s_sof=1 while (row, col) != (0, 0) forces a resync: the beat is written to address 0, col=1, and sync_err pulses.
  - CLEAR: writes clear_color, converted as above, to every address, row-major, one per cycle (64*W cycles). Returns to IDLE with no frame_done. col and row = 0 on exit.
- clear_req:
  - Accepted in IDLE or STREAM. It aborts any partial frame and wins over a simultaneous s_valid; that beat is not accepted because s_ready=0.
  - clear_req during CLEAR is ignored.
- Latency: an accepted beat at cycle N gives ctrl_en=1 with its addr/wdat at N+1. All write outputs are registered; ctrl_en is 0 on cycles with no write.
- No backpressure from the driver; one write per cycle sustained.
- Reset mid-frame or mid-clear: returns to IDLE next cycle. Writes already issued are not undone.

Optional Feature:
- Macro LED_FRAME_WRITER_BRIGHTNESS_EN.
- When defined:
  - Adds input port brightness[7:0].
  - Each 8-bit channel becomes (ch*brightness)>>8 before truncation, on both stream and clear paths.
  - brightness=255 gives ch - (ch>0 ? 1 : 0) per the formula.
  - Adds one pipeline stage: write at N+2; frame_done still one cycle after the last write.
- When undefined: no port, latency N+1.

Decomposition:
- Package led_pkg:
  - PANEL_W_BASE=64, PANEL_ROWS=64.
  - WR_MASK_RGB=4'b0111.
  - State enum {IDLE, STREAM, CLEAR}.
  - Function for the channel-pack conversion.
- One sub-module, led_color_pack: 24-bit in to 24-bit packed out, with optional brightness stage. It is shared by the stream and clear paths.

Test Plan:
- Full frame, CHAINED=2, s_sof on first beat, 8192 beats of s_data=24'hFC8004:
  - Writes addr 0..8191 in order, ctrl_wdat=24'h3F2001, ctrl_wr=4'b0111.
  - frame_done pulses once, one cycle after write 8191.
- Beat without sof in IDLE: no ctrl_en, sync_err=1. A following sof beat writes addr 0.
- Resync: s_sof asserted at pixel 300 of a frame: that beat writes addr 0, sync_err pulses, next beat writes addr 1.
- Row wrap: beat at col 127, row 0 writes 16'h007F; next beat writes 16'h0080.
- clear_req with clear_color=24'hFFFFFF coincident with a valid beat:
  - s_ready=0 that cycle, busy=1.
  - 8192 writes of 24'h3F3F3F, then IDLE, no frame_done.
- Reset asserted mid-clear at write 100: ctrl_en=0 and busy=0 the next cycle. The next sof frame starts at addr 0.
